// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the MIPS CPU bus memory model.
//   bus_state_t : slave handshake FSM states
//   LfsrTaps    : feedback mask for the 16-bit Fibonacci stall LFSR (taps 16,14,13,11)
//   lanes()     : number of byte lanes on a bus of the given width
package mips_cpu_bus_pkg;

   typedef enum logic [0:0] {Idle, Busy} bus_state_t;

   localparam logic [15:0] LfsrTaps = 16'hB400;

   function automatic int unsigned lanes(input int unsigned width);
      return width / 8;
   endfunction

endpackage

// File: rtl/mips_cpu_bus_memory_ws_if.sv
// Avalon-MM style request/response bundle between the CPU harness (master)
// and the memory model (slave).
//   read, write, byteenable, addr, writedata : master -> slave request
//   waitrequest, readdata                    : slave -> master response
interface mips_cpu_bus_memory_ws_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 24
);

   logic                    read;
   logic                    write;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   writedata;
   logic                    waitrequest;
   logic [DATA_WIDTH-1:0]   readdata;

   modport master (
      output read, write, byteenable, addr, writedata,
      input  waitrequest, readdata
   );

   modport slave (
      input  read, write, byteenable, addr, writedata,
      output waitrequest, readdata
   );

endinterface

// File: rtl/mips_cpu_bus_lfsr16.sv
// 16-bit Fibonacci LFSR used to add random stall cycles to memory accesses.
//   clk, rst_n : clock and asynchronous active-low reset (reloads seed)
//   advance    : step the register by one position this cycle
//   seed       : reset value, must be nonzero
//   value      : current register contents
module mips_cpu_bus_lfsr16
   import mips_cpu_bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   logic [15:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (advance) value_d = {value_q[14:0], ^(value_q & LfsrTaps)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) value_q <= seed;
      else        value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/mips_cpu_bus_memory_ws.sv
// Byte-addressed Avalon-MM slave memory with fixed wait states, for simulation.
//   clk, rst_n : clock and asynchronous active-low reset (contents survive reset)
//   bus        : slave side of the request/response bundle; lane i of the data
//                buses maps to byte (word-aligned addr) + i
// Optional feature: define MIPS_MEM_RANDOM_STALL_EN to add 0..7 LFSR-driven
// stall cycles per accepted request.
module mips_cpu_bus_memory_ws
   import mips_cpu_bus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 24,
   parameter int unsigned DEPTH_BYTES   = 2**24,
   parameter int unsigned WAIT_STATES   = 1,
   parameter string       RAM_INIT_FILE = "",
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input logic                     clk,
   input logic                     rst_n,
   mips_cpu_bus_memory_ws_if.slave bus
);

   localparam int unsigned Lanes = lanes(DATA_WIDTH);
   localparam int unsigned WcntW = $clog2(WAIT_STATES + 8);
   localparam int unsigned MemAw = $clog2(DEPTH_BYTES);

   logic [7:0] mem [DEPTH_BYTES];

   bus_state_t            state_q, state_d;
   logic [WcntW-1:0]      wcnt_q, wcnt_d, wcnt_load;
   logic                  done_q, done_d;
   logic                  access, accept;
   logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
   logic [2:0]            extra;
   logic                  req, illegal, waitrequest;
   logic [ADDR_WIDTH-1:0] base;
   logic [32:0]           lane_idx [Lanes];
   logic [Lanes-1:0]      lane_ok;

   assign req     = bus.read ^ bus.write;
   assign illegal = bus.read & bus.write;
   assign base    = bus.addr & ~ADDR_WIDTH'(Lanes - 1);

   always_comb begin
      for (int i = 0; i < int'(Lanes); i++) begin
         lane_idx[i] = 33'(base) + 33'(i);
         lane_ok[i]  = lane_idx[i] < 33'(DEPTH_BYTES);
      end
   end

`ifdef MIPS_MEM_RANDOM_STALL_EN
   logic [15:0] lfsr_value;
   logic [12:0] unused_lfsr;

   mips_cpu_bus_lfsr16 u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (accept),
      .seed    (LFSR_SEED),
      .value   (lfsr_value)
   );

   assign extra       = lfsr_value[2:0];
   assign unused_lfsr = lfsr_value[15:3];
`else
   logic [15:0] unused_seed;
   assign extra       = 3'd0;
   assign unused_seed = LFSR_SEED;
`endif

   assign wcnt_load = WcntW'(WAIT_STATES - 1) + WcntW'(extra);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= Idle;
         wcnt_q     <= '0;
         done_q     <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         done_q     <= done_d;
         readdata_q <= readdata_d;
      end
   end

   // Next state. done_q marks the completion cycle so the still-held request
   // is not taken as a fresh one.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      done_d  = 1'b0;
      access  = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         Idle: begin
            if (req && !done_q) begin
               accept = 1'b1;
               if (wcnt_load == '0) begin
                  access = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = Busy;
                  wcnt_d  = wcnt_load;
               end
            end
         end
         Busy: begin
            if (illegal) begin
               state_d = state_q;
            end else if (!req) begin
               state_d = Idle;
               wcnt_d  = '0;
            end else if (wcnt_q == WcntW'(1)) begin
               access  = 1'b1;
               done_d  = 1'b1;
               state_d = Idle;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q - WcntW'(1);
            end
         end
         default: state_d = Idle;
      endcase
      // Nothing may take effect at an edge seen while reset is held.
      access = access & rst_n;
      accept = accept & rst_n;
   end

   // Outputs
   always_comb begin
      waitrequest = 1'b1;
      if (rst_n) waitrequest = req & ~done_q;
   end

   always_comb begin
      readdata_d = readdata_q;
      if (access && bus.read) begin
         for (int i = 0; i < int'(Lanes); i++) begin
            readdata_d[8*i +: 8] = (bus.byteenable[i] && lane_ok[i]) ?
                                   mem[lane_idx[i][MemAw-1:0]] : 8'h00;
         end
      end
   end

   assign bus.waitrequest = waitrequest;
   assign bus.readdata    = readdata_q;

   // Backing store, deliberately not reset
   always_ff @(posedge clk) begin
      if (access && bus.write) begin
         for (int i = 0; i < int'(Lanes); i++) begin
            if (bus.byteenable[i] && lane_ok[i]) begin
               mem[lane_idx[i][MemAw-1:0]] <= bus.writedata[8*i +: 8];
            end
         end
      end
   end

`ifndef SYNTHESIS
   initial begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) mem[MemAw'(i)] = 8'h00;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (illegal) begin
            $display("%m: illegal request, read and write both high, addr %h", bus.addr);
         end
         if (access && !(&lane_ok)) begin
            $display("%m: warning, out-of-range access at addr %h", base);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mips_cpu_bus_memory_ws.sv
// Directed bench for mips_cpu_bus_memory_ws: three instances (1, 3 and 4 wait
// states) share one clock and reset; a transaction-level model predicts
// waitrequest and readdata every cycle.
module tb_mips_cpu_bus_memory_ws;

   localparam int          Depth = 4096;
   localparam logic [15:0] Seed  = 16'hACE1;

   logic        clk;
   logic        rst_n;
   int          sel;
   logic        rd, wr;
   logic [3:0]  be;
   logic [23:0] addr;
   logic [31:0] wd;
   logic        wreq;
   logic [31:0] rdata;

   logic [7:0]  mdl_mem [3][Depth];
   logic [15:0] mdl_lfsr [3];
   logic [31:0] exp_rdata [3];
   logic        exp_wreq;
   logic        chk_en;
   logic        lit_valid;
   logic [31:0] lit_exp;
   string       lit_name;
   int          n_checks;
   int          n_fail;
   int          lat_cnt;

   mips_cpu_bus_memory_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(24)) b1 ();
   mips_cpu_bus_memory_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(24)) b3 ();
   mips_cpu_bus_memory_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(24)) b4 ();

   assign b1.read = rd && sel == 0;  assign b1.write = wr && sel == 0;
   assign b3.read = rd && sel == 1;  assign b3.write = wr && sel == 1;
   assign b4.read = rd && sel == 2;  assign b4.write = wr && sel == 2;
   assign b1.byteenable = be;  assign b1.addr = addr;  assign b1.writedata = wd;
   assign b3.byteenable = be;  assign b3.addr = addr;  assign b3.writedata = wd;
   assign b4.byteenable = be;  assign b4.addr = addr;  assign b4.writedata = wd;

   assign wreq  = (sel == 0) ? b1.waitrequest : (sel == 1) ? b3.waitrequest : b4.waitrequest;
   assign rdata = (sel == 0) ? b1.readdata : (sel == 1) ? b3.readdata : b4.readdata;

   mips_cpu_bus_memory_ws #(
      .DATA_WIDTH(32), .ADDR_WIDTH(24), .DEPTH_BYTES(Depth), .WAIT_STATES(1), .LFSR_SEED(Seed)
   ) u_ws1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   mips_cpu_bus_memory_ws #(
      .DATA_WIDTH(32), .ADDR_WIDTH(24), .DEPTH_BYTES(Depth), .WAIT_STATES(3), .LFSR_SEED(Seed)
   ) u_ws3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   mips_cpu_bus_memory_ws #(
      .DATA_WIDTH(32), .ADDR_WIDTH(24), .DEPTH_BYTES(Depth), .WAIT_STATES(4), .LFSR_SEED(Seed)
   ) u_ws4 (.clk(clk), .rst_n(rst_n), .bus(b4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int ws_of(input int s);
      case (s)
         0:       return 1;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   // Latency of the next accepted request on instance s.
   task automatic next_lat(input int s, output int n);
      n = ws_of(s);
`ifdef MIPS_MEM_RANDOM_STALL_EN
      n = n + int'(mdl_lfsr[s] % 16'd8);
      mdl_lfsr[s] = {mdl_lfsr[s][14:0],
                     mdl_lfsr[s][15] ^ mdl_lfsr[s][13] ^ mdl_lfsr[s][12] ^ mdl_lfsr[s][10]};
`endif
   endtask

   function automatic logic [31:0] mdl_read(input int s, input logic [23:0] a,
                                           input logic [3:0] b);
      logic [31:0] r;
      int          w;
      r = 32'h0;
      w = int'(a) / 4 * 4;
      for (int i = 0; i < 4; i++) begin
         if (b[i] && w + i < Depth) r[8*i +: 8] = mdl_mem[s][w + i];
      end
      return r;
   endfunction

   task automatic mdl_write(input int s, input logic [23:0] a, input logic [3:0] b,
                            input logic [31:0] d);
      int w;
      w = int'(a) / 4 * 4;
      for (int i = 0; i < 4; i++) begin
         if (b[i] && w + i < Depth) mdl_mem[s][w + i] = d[8*i +: 8];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction: request held through the completion cycle.
   task automatic do_access(input int s, input bit is_wr, input logic [23:0] a,
                            input logic [3:0] b, input logic [31:0] d);
      int n;
      next_lat(s, n);
      sel = s;  rd = !is_wr;  wr = is_wr;  addr = a;  be = b;  wd = d;
      exp_wreq = 1'b1;
      repeat (n) step();
      exp_wreq = 1'b0;
      if (is_wr) mdl_write(s, a, b, d);
      else       exp_rdata[s] = mdl_read(s, a, b);
      step();
      rd = 1'b0;  wr = 1'b0;
   endtask

   task automatic lit(input string name, input logic [31:0] e);
      lit_name  = name;
      lit_exp   = e;
      lit_valid = 1'b1;
      @(negedge clk);
      #1;
      lit_valid = 1'b0;
      step();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if (wreq !== exp_wreq) begin
            n_fail++;
            $display("FAIL waitrequest[inst %0d] t=%0t: got %b want %b", sel, $time, wreq, exp_wreq);
         end
         n_checks++;
         if (rdata !== exp_rdata[sel]) begin
            n_fail++;
            $display("FAIL readdata[inst %0d] t=%0t: got %h want %h", sel, $time, rdata,
                     exp_rdata[sel]);
         end
         if (lit_valid) begin
            n_checks++;
            if (rdata !== lit_exp) begin
               n_fail++;
               $display("FAIL %s: got %h want %h", lit_name, rdata, lit_exp);
            end
         end
`ifdef MIPS_MEM_RANDOM_STALL_EN
         if (!rst_n || !(rd ^ wr)) begin
            lat_cnt = 0;
         end else if (wreq) begin
            lat_cnt++;
         end else begin
            n_checks++;
            if (lat_cnt < ws_of(sel) || lat_cnt > ws_of(sel) + 7) begin
               n_fail++;
               $display("FAIL stall_latency: got %0d want %0d..%0d", lat_cnt, ws_of(sel),
                        ws_of(sel) + 7);
            end
            lat_cnt = 0;
         end
`endif
      end
   end

   initial begin
      int n;
      sel = 0;  rd = 0;  wr = 0;  be = 0;  addr = 0;  wd = 0;
      chk_en = 0;  lit_valid = 0;  lit_exp = 0;  lit_name = "";
      n_checks = 0;  n_fail = 0;  lat_cnt = 0;
      exp_wreq = 1'b1;
      for (int s = 0; s < 3; s++) begin
         exp_rdata[s] = 32'h0;
         mdl_lfsr[s]  = Seed;
         for (int i = 0; i < Depth; i++) mdl_mem[s][i] = 8'h00;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      exp_wreq = 1'b0;

      // Single wait state: full word, partial and non-contiguous lanes
      do_access(0, 1, 24'h100, 4'b1111, 32'hDEADBEEF);
      do_access(0, 0, 24'h100, 4'b1111, 32'h0);
      lit("read_full", 32'hDEADBEEF);
      do_access(0, 1, 24'h100, 4'b0101, 32'h11223344);
      do_access(0, 0, 24'h100, 4'b1111, 32'h0);
      lit("read_after_be0101", 32'hDE22BE44);
      do_access(0, 0, 24'h100, 4'b1010, 32'h0);
      lit("read_be1010", 32'hDE00BE00);
      do_access(0, 0, 24'h102, 4'b1111, 32'h0);
      lit("unaligned_addr", 32'hDE22BE44);

      // Both strobes high: ignored, no stall
      sel = 0;  rd = 1;  wr = 1;  addr = 24'h100;  be = 4'b1111;  wd = 32'h0;
      exp_wreq = 1'b0;
      step();
      step();
      rd = 0;  wr = 0;
      step();
      do_access(0, 0, 24'h100, 4'b1111, 32'h0);
      lit("after_illegal", 32'hDE22BE44);

      // Out of range: write dropped (no wrap onto byte 0), read returns zero
      do_access(0, 1, 24'h1000, 4'b1111, 32'hFFFFFFFF);
      do_access(0, 0, 24'h000, 4'b1111, 32'h0);
      lit("no_wrap", 32'h0);
      do_access(0, 0, 24'h100, 4'b1111, 32'h0);
      do_access(0, 0, 24'h1000, 4'b1111, 32'h0);
      lit("oor_read", 32'h0);

      // Three wait states: withdrawn read leaves readdata alone
      do_access(1, 1, 24'h004, 4'b1111, 32'hCAFEF00D);
      do_access(1, 0, 24'h008, 4'b1111, 32'h0);
      next_lat(1, n);
      sel = 1;  rd = 1;  addr = 24'h004;  be = 4'b1111;
      exp_wreq = 1'b1;
      step();
      step();
      rd = 0;
      exp_wreq = 1'b0;
      step();
      do_access(1, 1, 24'h004, 4'b1111, 32'h00000001);
      lit("withdraw_no_stale", 32'h0);
      do_access(1, 0, 24'h004, 4'b1111, 32'h0);
      lit("write_after_withdraw", 32'h00000001);

      // Four wait states: reset in cycle 2 of a write
      do_access(2, 1, 24'h020, 4'b1111, 32'hA5A5A5A5);
      do_access(2, 0, 24'h020, 4'b1111, 32'h0);
      next_lat(2, n);
      sel = 2;  wr = 1;  addr = 24'h020;  be = 4'b1111;  wd = 32'h12345678;
      exp_wreq = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      wr = 0;
      for (int s = 0; s < 3; s++) begin
         exp_rdata[s] = 32'h0;
         mdl_lfsr[s]  = Seed;
      end
      lit("rdata_in_reset", 32'h0);
      rst_n = 1'b1;
      exp_wreq = 1'b0;
      do_access(2, 0, 24'h020, 4'b1111, 32'h0);
      lit("abandoned_write", 32'hA5A5A5A5);

`ifdef MIPS_MEM_RANDOM_STALL_EN
      for (int k = 0; k < 100; k++) do_access(0, 0, 24'(k * 4), 4'b1111, 32'h0);
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
